// File: rtl/pipeline_ctrl_if.sv
// Hazard/stall request and stage-control bundle between the core datapath and pipeline_ctrl.
// The master side raises hazard requests; the slave side (pipeline_ctrl) drives the stage controls.
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             icache_stall_i;
    logic             dcache_stall_i;
    logic             load_use_i;
    logic             branch_mispred_i;
    logic             mdu_req_i;
    logic             mdu_done_i;
    logic             cnt_clr_i;
    logic             mdu_go_o;
    logic             en_f_o;
    logic             en_d_o;
    logic             en_e_o;
    logic             en_m_o;
    logic             en_w_o;
    logic             flush_d_o;
    logic             flush_e_o;
    logic             flush_m_o;
    logic             flush_w_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output icache_stall_i, dcache_stall_i, load_use_i, branch_mispred_i,
               mdu_req_i, mdu_done_i, cnt_clr_i,
        input  mdu_go_o, en_f_o, en_d_o, en_e_o, en_m_o, en_w_o,
               flush_d_o, flush_e_o, flush_m_o, flush_w_o, stall_cnt_o
    );

    modport slave (
        input  icache_stall_i, dcache_stall_i, load_use_i, branch_mispred_i,
               mdu_req_i, mdu_done_i, cnt_clr_i,
        output mdu_go_o, en_f_o, en_d_o, en_e_o, en_m_o, en_w_o,
               flush_d_o, flush_e_o, flush_m_o, flush_w_o, stall_cnt_o
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the F/D/E/M/W pipeline: arbitrates cache stalls, MDU waits,
// redirects and load-use bubbles, and counts front-end stall cycles.
module pipeline_ctrl #(
    parameter int unsigned INIT_CYCLES = 4,
    parameter int unsigned CNT_W       = 32
) (
    input  logic           clk_i,
    input  logic           arst_i,
    pipeline_ctrl_if.slave bus
);
    localparam int unsigned INIT_W = $clog2(INIT_CYCLES + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_MWAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [INIT_W-1:0]  init_cnt_q, init_cnt_d;
    logic               done_seen_q, done_seen_d;
    logic [CNT_W-1:0]   stall_cnt_q;

    logic       mdu_go;
    logic [4:0] en;     // {f, d, e, m, w}
    logic [3:0] flush;  // {d, e, m, w}

    // Next state and stage controls; outputs depend on the current state and inputs only.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        done_seen_d = done_seen_q;
        mdu_go      = 1'b0;
        en          = 5'b11111;
        flush       = 4'b0000;

        case (state_q)
            ST_INIT: begin
                en         = 5'b01111;
                flush      = 4'b1111;
                init_cnt_d = init_cnt_q + INIT_W'(1);
                if (init_cnt_q == INIT_LAST) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (bus.dcache_stall_i) begin
                    en    = 5'b00001;
                    flush = 4'b0001;
                end else if (bus.mdu_req_i) begin
                    mdu_go      = 1'b1;
                    en          = 5'b00011;
                    flush       = 4'b0010;
                    done_seen_d = 1'b0;
                    state_d     = ST_MWAIT;
                end else if (bus.branch_mispred_i) begin
                    flush = 4'b1100;
                end else if (bus.load_use_i) begin
                    en    = 5'b00111;
                    flush = 4'b0100;
                end else if (bus.icache_stall_i) begin
                    en    = 5'b01111;
                    flush = 4'b1000;
                end
            end

            ST_MWAIT: begin
                if (bus.dcache_stall_i) begin
                    // A completion arriving under a D-cache stall is remembered until the stall clears.
                    en    = 5'b00001;
                    flush = 4'b0001;
                    if (bus.mdu_done_i) begin
                        done_seen_d = 1'b1;
                    end
                end else if (bus.mdu_done_i || done_seen_q) begin
                    done_seen_d = 1'b0;
                    state_d     = ST_RUN;
                end else begin
                    en    = 5'b00011;
                    flush = 4'b0010;
                end
            end

            default: begin
                en      = 5'b01111;
                flush   = 4'b1111;
                state_d = ST_INIT;
            end
        endcase
    end

    // State, init counter, pending-done flag and saturating stall counter.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            done_seen_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            done_seen_q <= done_seen_d;
            if (bus.cnt_clr_i) begin
                stall_cnt_q <= '0;
            end else if ((state_q != ST_INIT) && !en[4] && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.mdu_go_o    = mdu_go;
    assign bus.en_f_o      = en[4];
    assign bus.en_d_o      = en[3];
    assign bus.en_e_o      = en[2];
    assign bus.en_m_o      = en[1];
    assign bus.en_w_o      = en[0];
    assign bus.flush_d_o   = flush[3];
    assign bus.flush_e_o   = flush[2];
    assign bus.flush_m_o   = flush[1];
    assign bus.flush_w_o   = flush[0];
    assign bus.stall_cnt_o = stall_cnt_q;
endmodule
